// File: rtl/alu_pkg.sv
// Shared ALU-control codes, multiply FSM state encoding and operand helpers
// for the multiply/HI-LO stage.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    typedef logic [4:0] alu_ctrl_t;
    typedef logic [1:0] mult_state_t;

    localparam alu_ctrl_t ALU_MULT  = 5'b00011;
    localparam alu_ctrl_t ALU_MULTU = 5'b00100;
    localparam alu_ctrl_t ALU_MUL   = 5'b10011;
    localparam alu_ctrl_t ALU_MADD  = 5'b10100;
    localparam alu_ctrl_t ALU_MSUB  = 5'b10101;
    localparam alu_ctrl_t ALU_MFHI  = 5'b10111;
    localparam alu_ctrl_t ALU_MFLO  = 5'b11000;
    localparam alu_ctrl_t ALU_MTHI  = 5'b11001;
    localparam alu_ctrl_t ALU_MTLO  = 5'b11010;

    localparam mult_state_t ST_IDLE = 2'd0;
    localparam mult_state_t ST_CALC = 2'd1;
    localparam mult_state_t ST_WB   = 2'd2;

    function automatic logic is_mult_op(input alu_ctrl_t code);
        return (code == ALU_MULT) || (code == ALU_MULTU) || (code == ALU_MUL) ||
               (code == ALU_MADD) || (code == ALU_MSUB);
    endfunction

    // Magnitude of a two's-complement operand; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_mult_unit_if.sv
// Command/response bundle between the decode/execute stage and the
// multiply/HI-LO stage.
interface hilo_mult_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              Start;
    logic [4:0]        ALUControl;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Busy;
    logic              Stall;
    logic              Done;
    logic [DATA_W-1:0] Result;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output Start, ALUControl, A, B,
        input  Busy, Stall, Done, Result, HI, LO
    );

    modport slave (
        input  Start, ALUControl, A, B,
        output Busy, Stall, Done, Result, HI, LO
    );
endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: unsigned multiplicand/multiplier/accumulator
// registers, loaded on load and advanced one bit per step.
module mult_shift_add #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplier_in,
    output logic [2*W-1:0] acc,
    output logic           mplier_done
);

    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   mplier_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{W{1'b0}}, mcand_in};
            mplier_q <= mplier_in;
            acc_q    <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign acc = acc_q;
    // Multiplier will be zero once the step in progress has shifted it.
    assign mplier_done = (mplier_q[W-1:1] == '0);

endmodule

// File: rtl/hilo_mult_unit.sv
// Multiply/HI-LO stage: FSM, architectural HI/LO and result mux around a
// shift-add core. Define EARLY_TERM_EN to leave CALC once the multiplier is zero.
module hilo_mult_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input logic              Clk,
    input logic              Rst,
    hilo_mult_unit_if.slave  bus
);

    import alu_pkg::*;

`ifdef EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    mult_state_t       state_q, state_d;
    alu_ctrl_t         op_q;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hi_q, lo_q, result_q;
    logic              done_q;

    logic                idle, accept_mult, step, calc_last, mplier_done, op_signed;
    logic [DATA_W-1:0]   a_mag, b_mag, result_mux;
    logic [2*DATA_W-1:0] acc, prod, hilo_cur, hilo_next;

    assign idle        = (state_q == ST_IDLE);
    assign accept_mult = idle & bus.Start & is_mult_op(bus.ALUControl);
    assign op_signed   = (bus.ALUControl != ALU_MULTU);
    assign a_mag       = abs_val(bus.A, op_signed);
    assign b_mag       = abs_val(bus.B, op_signed);
    assign step        = (state_q == ST_CALC);
    assign calc_last   = (cnt_q == CNT_W'(DATA_W - 1)) | (EarlyTerm & mplier_done);

    mult_shift_add #(
        .W (DATA_W)
    ) u_core (
        .clk         (Clk),
        .rst_n       (Rst),
        .load        (accept_mult),
        .step        (step),
        .mcand_in    (a_mag),
        .mplier_in   (b_mag),
        .acc         (acc),
        .mplier_done (mplier_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_mult) state_d = ST_CALC;
            ST_CALC: if (calc_last) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign prod     = sign_q ? (~acc + 1'b1) : acc;
    assign hilo_cur = {hi_q, lo_q};

    always_comb begin
        hilo_next = hilo_cur;
        case (op_q)
            ALU_MULT, ALU_MULTU: hilo_next = prod;
            ALU_MADD:            hilo_next = hilo_cur + prod;
            ALU_MSUB:            hilo_next = hilo_cur - prod;
            default:             hilo_next = hilo_cur;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_WB);
            if (accept_mult) begin
                op_q   <= bus.ALUControl;
                sign_q <= op_signed & (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
                cnt_q  <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_WB) begin
                {hi_q, lo_q} <= hilo_next;
                result_q     <= (op_q == ALU_MUL) ? prod[DATA_W-1:0] : '0;
            end else if (idle && bus.Start) begin
                if (bus.ALUControl == ALU_MTHI) hi_q <= bus.A;
                if (bus.ALUControl == ALU_MTLO) lo_q <= bus.A;
            end
        end
    end

    // An accepted MFHI/MFLO wins over a MUL product presented in the same Done cycle.
    always_comb begin
        result_mux = '0;
        if (idle && bus.Start && (bus.ALUControl == ALU_MFHI)) begin
            result_mux = hi_q;
        end else if (idle && bus.Start && (bus.ALUControl == ALU_MFLO)) begin
            result_mux = lo_q;
        end else if (done_q && (op_q == ALU_MUL)) begin
            result_mux = result_q;
        end
    end

    assign bus.Busy   = ~idle;
    assign bus.Stall  = bus.Start & ~idle;
    assign bus.Done   = done_q;
    assign bus.Result = result_mux;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed self-checking bench for hilo_mult_unit.
module tb_hilo_mult_unit;

    localparam logic [4:0] C_MULT  = 5'b00011;
    localparam logic [4:0] C_MULTU = 5'b00100;
    localparam logic [4:0] C_MUL   = 5'b10011;
    localparam logic [4:0] C_MADD  = 5'b10100;
    localparam logic [4:0] C_MSUB  = 5'b10101;
    localparam logic [4:0] C_MFHI  = 5'b10111;
    localparam logic [4:0] C_MFLO  = 5'b11000;
    localparam logic [4:0] C_MTHI  = 5'b11001;
    localparam logic [4:0] C_MTLO  = 5'b11010;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hilo_mult_unit_if #(.DATA_W(32)) bus ();

    hilo_mult_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start      = 1'b1;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    // Returns at the falling edge inside the Done cycle.
    task automatic run_mult(input string tag, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int cyc;
        issue(op, a, b);
        chk({tag, "_busy"}, bus.Busy, 1'b1);
        cyc = 0;
        while (!bus.Done && cyc < 60) begin
            @(negedge Clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, bus.Done, 1'b1);
`ifndef EARLY_TERM_EN
        chk({tag, "_latency"}, cyc, 33);
`endif
    endtask

    task automatic after_done(input string tag);
        @(negedge Clk);
        chk({tag, "_done_pulse_len"}, bus.Done, 1'b0);
    endtask

    initial begin
        int  stalls;
        bit  seen;
        bus.Start      = 1'b0;
        bus.ALUControl = '0;
        bus.A          = '0;
        bus.B          = '0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        chk("rst_result", bus.Result, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        // -3 * 7 = -21
        run_mult("mult", C_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFEB);
        chk("mult_result_zero", bus.Result, 32'h0);
        after_done("mult");

        run_mult("multu", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
        chk("multu_lo", bus.LO, 32'h0000_0001);
        after_done("multu");

        issue(C_MTHI, 32'd0, 32'd0);
        issue(C_MTLO, 32'd10, 32'd0);
        chk("mthi_hi", bus.HI, 32'h0);
        chk("mtlo_lo", bus.LO, 32'd10);
        chk("mtx_busy", bus.Busy, 1'b0);
        run_mult("madd", C_MADD, 32'd2, 32'd3);
        chk("madd_hi", bus.HI, 32'h0);
        chk("madd_lo", bus.LO, 32'd16);
        after_done("madd");
        run_mult("msub", C_MSUB, 32'd4, 32'd5);
        chk("msub_hi", bus.HI, 32'hFFFF_FFFF);
        chk("msub_lo", bus.LO, 32'hFFFF_FFFC);
        after_done("msub");

        bus.Start = 1'b1; bus.ALUControl = C_MFLO;
        #1;
        chk("mflo_result", bus.Result, 32'hFFFF_FFFC);
        chk("mflo_stall", bus.Stall, 1'b0);
        @(negedge Clk);
        bus.ALUControl = 5'b00000; bus.A = 32'h1234_5678;
        #1;
        chk("other_result", bus.Result, 32'h0);
        @(negedge Clk);
        bus.Start = 1'b0;
        chk("other_busy", bus.Busy, 1'b0);
        chk("other_hi", bus.HI, 32'hFFFF_FFFF);

        // MFHI held behind a multiply until the Done cycle.
        bus.Start = 1'b1; bus.ALUControl = C_MULT; bus.A = 32'h0001_0000; bus.B = 32'h0001_0000;
        @(negedge Clk);
        bus.ALUControl = C_MFHI;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.Busy) break;
            chk("stall_while_busy", bus.Stall, 1'b1);
            stalls++;
            @(negedge Clk);
        end
        chk("stall_cycles", stalls, 33);
        chk("stall_done", bus.Done, 1'b1);
        chk("stall_released", bus.Stall, 1'b0);
        chk("mfhi_after_mult", bus.Result, 32'h0000_0001);
        chk("mfhi_lo", bus.LO, 32'h0);
        @(negedge Clk);
        bus.Start = 1'b0;

        // Reset in the middle of a multiply.
        issue(C_MULT, 32'd3, 32'd5);
        repeat (9) @(negedge Clk);
        chk("pre_rst_busy", bus.Busy, 1'b1);
        Rst = 1'b0;
        #1;
        chk("midrst_busy", bus.Busy, 1'b0);
        chk("midrst_hi", bus.HI, 32'h0);
        chk("midrst_lo", bus.LO, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 1'b0);

        issue(C_MTHI, 32'd5, 32'd0);
        issue(C_MTLO, 32'd6, 32'd0);
        run_mult("mul", C_MUL, 32'h0001_0000, 32'h0001_0003);
        chk("mul_result", bus.Result, 32'h0003_0000);
        chk("mul_hi", bus.HI, 32'd5);
        chk("mul_lo", bus.LO, 32'd6);
        after_done("mul");
        chk("mul_result_cleared", bus.Result, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Sequential multiply/HI-LO stage directly downstream of the ALU control decoder.
- Consumes the 5-bit ALUControl code for the multiply-class and HI/LO-move operations: MULT, MULTU, MUL, MADD, MSUB, MFHI, MFLO, MTHI, MTLO.
- Runs a 32-step radix-2 shift-add multiplier and owns the architectural HI/LO registers.
- Stalls upstream while a multiply is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- Clk  in  1  system clock; rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  operation valid from the decode/execute stage.
- ALUControl  in  5  operation code, sampled only with Start.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Busy  out  1  high while a multiply is in flight (state != IDLE).
- Stall  out  1  combinational; equals Start & Busy.
- Done  out  1  one-cycle pulse when a multiply completes.
- Result  out  32  GPR write data for MFHI/MFLO/MUL.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, HI=LO=0, Busy=0, Done=0, counter=0, all datapath registers 0. A reset mid-multiply discards the operation; no Done is produced.
- States and transitions:
  - IDLE: if Start and the code is MULT/MULTU/MUL/MADD/MSUB, latch op, |A|, |B|, sign=A[31]^B[31] (signed ops only), clear the 64-bit accumulator, counter=0, go to CALC.
  - IDLE, MTHI/MTLO: if Start, write HI=A or LO=A at that edge; stay in IDLE.
  - IDLE, MFHI/MFLO: if Start, Result=HI or LO combinationally in the same cycle; no state change.
  - IDLE, other codes: Start with any other code is ignored; Result=0.
  - CALC: each edge, if multiplier bit0=1 then acc += multiplicand; multiplicand <<= 1, multiplier >>= 1, counter++. After the step with counter==31, go to WB.
  - WB: one edge. Compute p = sign ? -acc : acc, as 64 bits.
    - MULT/MULTU: {HI,LO}=p.
    - MADD: {HI,LO}+=p.
    - MSUB: {HI,LO}-=p.
    - MUL: HI/LO unchanged; Result register = p[31:0].
    - All ops: Done=1 for the following cycle; return to IDLE.
- Arithmetic width rules:
  - MULTU: operands are taken unsigned; sign=0.
  - MULT/MUL/MADD/MSUB: signed.
  - MADD/MSUB wrap modulo 2^64; no overflow flag.
- Latency: the accept edge is E0. Busy is high from E0 until E33. Done is high in the cycle after E33. Fixed 33-cycle throughput.
- Result:
  - Combinational HI/LO during IDLE+Start for MFHI/MFLO.
  - Low product while Done=1 for MUL.
  - 0 otherwise.
- Stall rules:
  - Any Start while Busy asserts Stall. The command is not accepted and upstream holds it.
  - An MFHI/MFLO stalled behind a multiply returns the post-WB value once it is accepted.
- Simultaneous events:
  - Start in the Done cycle is accepted, because state is IDLE.
  - Reset overrides everything.

Optional Feature:
- EARLY_TERM_EN defined: CALC exits to WB as soon as the shifted multiplier is zero, so latency varies from 2 to 33 cycles. Done/Busy semantics are unchanged.
- Not defined: fixed 32 iterations.

Decomposition:
- Package alu_pkg:
  - ALUControl code constants, with MULT=00011, MULTU=00100, MUL=10011, MADD=10100, MSUB=10101, MFHI=10111, MFLO=11000, MTHI=11001, MTLO=11010.
  - State encoding IDLE/CALC/WB.
  - DATA_W.
- Sub-module mult_shift_add: multiplicand/multiplier/acc registers and the one-step update, controlled by load/step inputs.
- The top level holds the FSM, HI/LO, and the result mux.

Test Plan:
- MULT A=0xFFFFFFFD, B=7 -> Done exactly 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MTHI 0, MTLO 10, MADD 2*3 -> HI=0, LO=16. Then MSUB 4*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFC.
- MFHI asserted during a MULT 0x10000*0x10000 -> Stall=1 every busy cycle. After Done, MFHI is accepted with Result=0x00000001.
- Rst driven low 10 cycles into a MULT -> Busy=0 immediately, HI=LO=0, no Done pulse.
- Preload HI=0x5, LO=0x6; MUL 0x10000*0x10003 -> Result=0x00030000 in the Done cycle; HI/LO stay 0x5/0x6.
